// File: rtl/prog_loader_if.sv
// Host-link byte stream, instruction-memory write port and session status of the program loader.
`timescale 1ns/1ps
interface prog_loader_if;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       err;

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err
    );

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err
    );
endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: SYNC, LEN, payload, CHK; writes payload into
// instruction memory and holds the CPU in reset until a frame verifies.
`timescale 1ns/1ps
module prog_loader #(
    parameter int         TIMEOUT   = 1024,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic          clk,
    input  logic          reset,
    prog_loader_if.slave  bus
);
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SYNC, LEN, DATA, CHK, DONE, ERR} state_t;

    state_t          state_q, state_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      sum_q, sum_d;
    logic [7:0]      idx_q, idx_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic            we_q, we_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            active;
    logic            accept;
    logic [7:0]      sum_next;

    assign active   = (state_q == SYNC) || (state_q == LEN) ||
                      (state_q == DATA) || (state_q == CHK);
    assign accept   = active && bus.in_valid;
    assign sum_next = sum_q + bus.in_data;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        idle_d  = idle_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (bus.start) begin
                    state_d = SYNC;
                    idx_d   = 8'd0;
                    sum_d   = 8'd0;
                    idle_d  = '0;
                end
            end
            SYNC: begin
                if (accept && (bus.in_data == SYNC_BYTE)) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (accept) begin
                    if (bus.in_data == 8'd0) begin
                        state_d = ERR;
                    end else begin
                        len_d   = bus.in_data;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = idx_q;
                    wdata_d = bus.in_data;
                    sum_d   = sum_next;
                    idx_d   = idx_q + 8'd1;
                    if (idx_q == len_q - 8'd1) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (accept) begin
                    state_d = (sum_next == 8'd0) ? DONE : ERR;
                end
            end
            default: state_d = IDLE;
        endcase

        // Inter-byte watchdog; SYNC may wait for the host indefinitely.
        if ((state_q == LEN) || (state_q == DATA) || (state_q == CHK)) begin
            if (accept) begin
                idle_d = '0;
            end else if (idle_q == IW'(TIMEOUT - 1)) begin
                state_d = ERR;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= 8'd0;
            idle_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= 8'd0;
            wdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            idle_q  <= idle_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Length and running sum are reinitialised by every start, so they need no reset.
    always_ff @(posedge clk) begin
        len_q <= len_d;
        sum_q <= sum_d;
    end

    assign bus.in_ready  = active;
    assign bus.busy      = active;
    assign bus.done      = (state_q == DONE);
    assign bus.err       = (state_q == ERR);
    assign bus.cpu_hold  = (state_q != DONE);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame loads, checksum/length errors, timeout, reset abort.
`timescale 1ns/1ps
module tb_prog_loader;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic [7:0] wa[$];
    logic [7:0] wd[$];
    int         wc[$];

    always #5 clk = ~clk;

    prog_loader_if bus();

    prog_loader #(.TIMEOUT(TO), .SYNC_BYTE(8'hA5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_wdata);
            wc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int i, input logic [7:0] a, input logic [7:0] d);
        logic [31:0] obs;
        obs = (i < wa.size()) ? {16'h0, wa[i], wd[i]} : 32'hFFFF_FFFF;
        chk($sformatf("%s_wr%0d", tag, i), obs, {16'h0, a, d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_mem_we"},   bus.mem_we,   0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"},bus.mem_wdata,0);
        chk({tag, "_cpu_hold"}, bus.cpu_hold, 1);
        chk({tag, "_busy"},     bus.busy,     0);
        chk({tag, "_done"},     bus.done,     0);
        chk({tag, "_err"},      bus.err,      0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        reset = 1'b1;
        tick();
        chk("idle_busy", bus.busy, 0);

        // Basic load
        clear_log();
        pulse_start();
        chk("basic_busy", bus.busy, 1);
        chk("basic_ready", bus.in_ready, 1);
        send(8'hA5); send(8'h03); send(8'h10); send(8'h20); send(8'h30); send(8'hA0);
        chk("basic_n", wa.size(), 3);
        chk_wr("basic", 0, 8'h00, 8'h10);
        chk_wr("basic", 1, 8'h01, 8'h20);
        chk_wr("basic", 2, 8'h02, 8'h30);
        chk("basic_consec", (wc.size() == 3) ? (wc[2] - wc[0]) : -1, 2);
        chk("basic_done", bus.done, 1);
        chk("basic_hold", bus.cpu_hold, 0);
        chk("basic_err", bus.err, 0);
        chk("basic_busy_end", bus.busy, 0);
        chk("basic_we_end", bus.mem_we, 0);

        // Start in DONE, then bad checksum
        clear_log();
        pulse_start();
        chk("restart_done", bus.done, 0);
        chk("restart_hold", bus.cpu_hold, 1);
        chk("restart_busy", bus.busy, 1);
        send(8'hA5); send(8'h02); send(8'h01); send(8'h02); send(8'h00);
        chk("badchk_n", wa.size(), 2);
        chk_wr("badchk", 0, 8'h00, 8'h01);
        chk_wr("badchk", 1, 8'h01, 8'h02);
        chk("badchk_err", bus.err, 1);
        chk("badchk_hold", bus.cpu_hold, 1);
        chk("badchk_done", bus.done, 0);

        // Sync hunt
        clear_log();
        pulse_start();
        chk("hunt_err_cleared", bus.err, 0);
        send(8'h00); send(8'hFF); send(8'hA5); send(8'h01); send(8'h7F); send(8'h81);
        chk("hunt_n", wa.size(), 1);
        chk_wr("hunt", 0, 8'h00, 8'h7F);
        chk("hunt_done", bus.done, 1);

        // Zero length
        clear_log();
        pulse_start();
        send(8'hA5); send(8'h00);
        chk("zlen_err", bus.err, 1);
        tick(); tick();
        chk("zlen_n", wa.size(), 0);

        // Gaps then timeout
        clear_log();
        pulse_start();
        send(8'hA5); repeat (5) tick();
        send(8'h02); repeat (5) tick();
        send(8'h55); repeat (5) tick();
        chk("gap_n", wa.size(), 1);
        chk_wr("gap", 0, 8'h00, 8'h55);
        chk("gap_busy", bus.busy, 1);
        repeat (TO - 1 - 5) tick();
        chk("to_before_err", bus.err, 0);
        chk("to_before_busy", bus.busy, 1);
        tick();
        chk("to_err", bus.err, 1);
        chk("to_busy", bus.busy, 0);

        // Reset mid-frame with a write pending
        clear_log();
        pulse_start();
        send(8'hA5); send(8'h04); send(8'h11);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h22;
        tick();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        repeat (3) tick();
        chk("midrst_n", wa.size(), 1);
        chk_wr("midrst", 0, 8'h00, 8'h11);
        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        repeat (4) tick();
        chk("postrst_busy", bus.busy, 0);
        chk("postrst_ready", bus.in_ready, 0);
        chk("postrst_hold", bus.cpu_hold, 1);
        chk("postrst_n", wa.size(), 1);
        bus.in_valid = 1'b0;
        pulse_start();
        chk("postrst_start_busy", bus.busy, 1);

        // Start while busy is ignored
        clear_log();
        send(8'hA5); send(8'h02); send(8'h33);
        bus.start = 1'b1;
        send(8'h44);
        bus.start = 1'b0;
        chk("busystart_busy", bus.busy, 1);
        send(8'h89);
        chk("busystart_n", wa.size(), 2);
        chk_wr("busystart", 0, 8'h00, 8'h33);
        chk_wr("busystart", 1, 8'h01, 8'h44);
        chk("busystart_done", bus.done, 1);
        chk("busystart_hold", bus.cpu_hold, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 1024: the number of idle cycles allowed between accepted bytes inside a frame.
REQ-002 The block SHALL have parameter SYNC_BYTE, default 8'hA5: the frame start marker.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: requests a new load session.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data holds a byte.
REQ-007 The block SHALL have port in_data, input, 8 bits: byte stream from the host link.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-009 The block SHALL have port mem_we, output, 1 bit: write strobe to instruction memory.
REQ-010 The block SHALL have port mem_addr, output, 8 bits: instruction memory write address.
REQ-011 The block SHALL have port mem_wdata, output, 8 bits: instruction memory write data.
REQ-012 The block SHALL have port cpu_hold, output, 1 bit: holds the CPU in reset while high.
REQ-013 The block SHALL have ports busy, done and err, each output, 1 bit: session active, load succeeded, load failed.

Function
REQ-014 A byte SHALL be accepted only in a cycle where in_valid and in_ready are both high.
REQ-015 The frame format SHALL be: SYNC_BYTE, then LEN (1..255), then LEN payload bytes, then CHK.
REQ-016 A frame SHALL be valid only when the 8-bit sum of all payload bytes plus CHK, modulo 256, equals 0.
REQ-017 The FSM SHALL have exactly the states IDLE, SYNC, LEN, DATA, CHK, DONE and ERR.
REQ-018 in_ready SHALL be high in SYNC, LEN, DATA and CHK, and low in all other states.
REQ-019 busy SHALL be high in SYNC, LEN, DATA and CHK, and low in all other states.
REQ-020 In IDLE, DONE or ERR, a start pulse SHALL move the FSM to SYNC, clear done and err, and zero the byte index and running sum.
REQ-021 start SHALL be ignored while busy is high.
REQ-022 In SYNC, an accepted byte equal to SYNC_BYTE SHALL move the FSM to LEN; any other accepted byte SHALL be discarded with the FSM staying in SYNC.
REQ-023 In LEN, an accepted 0x00 SHALL move the FSM to ERR; any other accepted value SHALL be latched as the length and move the FSM to DATA.
REQ-024 In DATA, each accepted byte SHALL be added mod 256 to the running sum.
REQ-025 Each accepted DATA byte SHALL produce exactly one mem_we pulse in the next cycle, with mem_addr equal to the byte index and mem_wdata equal to the byte; the index SHALL then increment.
REQ-026 Write latency SHALL be one cycle after acceptance.
REQ-027 Back-to-back DATA bytes SHALL produce back-to-back writes at consecutive addresses.
REQ-028 When the payload byte with index LEN-1 is accepted, the FSM SHALL move to CHK.
REQ-029 The payload address range SHALL be 0..LEN-1; no wrap-around is possible because LEN is at most 255.
REQ-030 In CHK, an accepted byte SHALL move the FSM to DONE if the REQ-016 sum is 0, and to ERR otherwise.
REQ-031 On a checksum failure, memory contents already written SHALL be left unchanged; no rollback.
REQ-032 In LEN, DATA and CHK, a counter SHALL count cycles without an accepted byte and clear on every acceptance.
REQ-033 When the idle counter reaches TIMEOUT, the FSM SHALL move to ERR.
REQ-034 SYNC SHALL have no timeout.
REQ-035 In DONE, cpu_hold SHALL be 0 and done SHALL be 1.
REQ-036 In every state other than DONE, cpu_hold SHALL be 1.
REQ-037 In ERR, err SHALL be 1 and cpu_hold SHALL remain 1.
REQ-038 done and err SHALL each hold their value until the next accepted start.
REQ-039 mem_we SHALL never be asserted outside the cycle following an accepted DATA byte.

Reset
REQ-040 While reset is low, the FSM SHALL be forced to IDLE asynchronously.
REQ-041 While reset is low, the outputs SHALL be: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, busy=0, done=0, err=0.
REQ-042 A reset asserted mid-frame SHALL abort the session immediately.
REQ-043 A write pulse pending when reset is asserted SHALL be suppressed.
REQ-044 The block SHALL leave reset into IDLE; a load requires a new start.

Verification
REQ-045 Basic load: start, then A5 03 10 20 30 A0 with in_valid held high -> writes (0,10), (1,20), (2,30) on consecutive cycles, then DONE with cpu_hold=0 and done=1.
REQ-046 Bad checksum: start, then A5 02 01 02 00 -> writes (0,01), (1,02), then ERR with err=1, cpu_hold=1 and done=0.
REQ-047 Sync hunt and zero length: start, then 00 FF A5 01 7F 81 -> 00 and FF discarded, one write (0,7F), DONE; separately, start then A5 00 -> ERR with no writes.
REQ-048 Backpressure gaps and timeout: start, then A5 02 55 with 5-cycle gaps between bytes -> writes still occur; then stall TIMEOUT cycles -> ERR.
REQ-049 Reset mid-frame: start, A5 04 11 22, assert reset -> all outputs at reset values, no further mem_we; after release the block stays in IDLE until a new start.
REQ-050 Start while busy: start pulse during DATA -> ignored, frame completes normally; start in DONE -> done cleared, cpu_hold returns to 1, FSM in SYNC.
